// File: rtl/brew_pkg.sv
// Brew sequencer shared definitions: stage codes and stage-order helper.
package brew_pkg;

  typedef logic [2:0] stage_t;

  localparam stage_t ST_IDLE   = 3'd0;
  localparam stage_t ST_HEAT   = 3'd1;
  localparam stage_t ST_COFFEE = 3'd2;
  localparam stage_t ST_SUGAR  = 3'd3;
  localparam stage_t ST_MILK   = 3'd4;
  localparam stage_t ST_DRAIN  = 3'd5;
  localparam stage_t ST_FAULT  = 3'd6;

  localparam stage_t ST_FIRST  = ST_HEAT;
  localparam stage_t ST_LAST   = ST_MILK;

  // en[i] enables stage code i+1; returns ST_IDLE when nothing is left
  function automatic stage_t first_enabled(
    input stage_t     from,
    input logic [3:0] en
  );
    stage_t s;
    s = ST_IDLE;
    for (int i = 3; i >= 0; i--) begin
      if (en[i] && (stage_t'(i + 1) >= from)) begin
        s = stage_t'(i + 1);
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/brew_watchdog.sv
// Expiry watchdog: counts while enabled, flags when the
// expected timer pulse is overdue.
module brew_watchdog #(
  parameter int unsigned WDOG_CYCLES = 500_000_000
) (
  input  logic clk_100MHz,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam int W = $clog2(WDOG_CYCLES) + 1;
  localparam logic [W-1:0] LAST = W'(WDOG_CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LAST)) begin
      cnt <= cnt + W'(1);
    end
  end

  assign timeout = enable && (cnt == LAST);

endmodule

// File: rtl/brew_sequencer.sv
// Brew controller: HEAT -> COFFEE (x1/x2) -> SUGAR -> MILK,
// one shared timer per stage, cancel drain and expiry watchdog.
module brew_sequencer
  import brew_pkg::*;
#(
  parameter logic [1:0]  T_HEAT      = 2'd3,
  parameter logic [1:0]  T_COFFEE    = 2'd2,
  parameter logic [1:0]  T_SUGAR     = 2'd1,
  parameter logic [1:0]  T_MILK      = 2'd2,
  parameter int unsigned WDOG_CYCLES = 500_000_000
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       start,
  input  logic       size_large,
  input  logic       add_sugar,
  input  logic       add_milk,
  input  logic       cancel,
  input  logic       t_expired,
  output logic       timer_start,
  output logic [1:0] timer_value,
  output logic       heater_on,
  output logic       coffee_valve,
  output logic       sugar_valve,
  output logic       milk_valve,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [2:0] stage
);

  stage_t state_q, state_d;
  logic   wait_q, wait_d;
  logic   pass_q, pass_d;
  logic   fault_q, fault_d;
  logic   done_q, done_d;
  logic   start_q, capture;
  logic   opt_large_q, opt_sugar_q, opt_milk_q;
  logic   is_stage, start_rise, wd_timeout;
  logic   sel_sugar, sel_milk;
  logic [3:0] en;

  assign is_stage   = (state_q >= ST_FIRST) && (state_q <= ST_LAST);
  assign start_rise = start && !start_q;

  // In IDLE the options are not captured yet, so look at the pins
  assign sel_sugar = (state_q == ST_IDLE) ? add_sugar : opt_sugar_q;
  assign sel_milk  = (state_q == ST_IDLE) ? add_milk  : opt_milk_q;
  assign en = {sel_milk  && (T_MILK   != 2'd0),
               sel_sugar && (T_SUGAR  != 2'd0),
               T_COFFEE != 2'd0,
               T_HEAT   != 2'd0};

  brew_watchdog #(
    .WDOG_CYCLES (WDOG_CYCLES)
  ) u_wdog (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .clear      (is_stage && !wait_q),
    .enable     ((is_stage && wait_q) || (state_q == ST_DRAIN)),
    .timeout    (wd_timeout)
  );

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wait_q      <= 1'b0;
      pass_q      <= 1'b0;
      fault_q     <= 1'b0;
      done_q      <= 1'b0;
      start_q     <= 1'b0;
      opt_large_q <= 1'b0;
      opt_sugar_q <= 1'b0;
      opt_milk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      pass_q  <= pass_d;
      fault_q <= fault_d;
      done_q  <= done_d;
      start_q <= start;
      if (capture) begin
        opt_large_q <= size_large;
        opt_sugar_q <= add_sugar;
        opt_milk_q  <= add_milk;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    pass_d  = pass_q;
    fault_d = fault_q;
    done_d  = 1'b0;
    capture = 1'b0;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (start_rise) begin
          capture = 1'b1;
          fault_d = 1'b0;
          wait_d  = 1'b0;
          pass_d  = 1'b0;
          state_d = first_enabled(ST_FIRST, en);
          done_d  = (state_d == ST_IDLE);
        end
      end
      is_stage: begin
        if (cancel) begin
          state_d = ST_DRAIN;
          wait_d  = 1'b0;
        end else if (!wait_q) begin
          wait_d = 1'b1;
        end else if (t_expired) begin
          wait_d = 1'b0;
          if ((state_q == ST_COFFEE) && opt_large_q && !pass_q) begin
            pass_d = 1'b1;
          end else begin
            state_d = first_enabled(stage_t'(state_q + 3'd1), en);
            done_d  = (state_d == ST_IDLE);
          end
        end else if (wd_timeout) begin
          state_d = ST_FAULT;
          wait_d  = 1'b0;
          fault_d = 1'b1;
        end
      end
      (state_q == ST_DRAIN): begin
        if (t_expired || wd_timeout) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        wait_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    timer_value  = 2'd0;
    heater_on    = 1'b0;
    coffee_valve = 1'b0;
    sugar_valve  = 1'b0;
    milk_valve   = 1'b0;
    unique case (1'b1)
      (state_q == ST_HEAT): begin
        heater_on   = 1'b1;
        timer_value = T_HEAT;
      end
      (state_q == ST_COFFEE): begin
        coffee_valve = 1'b1;
        timer_value  = T_COFFEE;
      end
      (state_q == ST_SUGAR): begin
        sugar_valve = 1'b1;
        timer_value = T_SUGAR;
      end
      (state_q == ST_MILK): begin
        milk_valve  = 1'b1;
        timer_value = T_MILK;
      end
      default: ;
    endcase
    timer_start = is_stage && !wait_q;
    busy        = is_stage || (state_q == ST_DRAIN);
  end

  assign done  = done_q;
  assign fault = fault_q;
  assign stage = state_q;

endmodule

// File: tb/tb_brew_sequencer.sv
// Scoreboard bench for brew_sequencer with a behavioural timer
// (expiry T*4 cycles after timer_start) and WDOG_CYCLES=64.
module tb_brew_sequencer;
  import brew_pkg::*;

  localparam int EV_DONE = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, start2, size_large, add_sugar, add_milk, cancel;
  logic suppress;
  logic t_exp1, t_exp2;
  logic ts1, heat1, cof1, sug1, milk1, busy1, done1, fault1;
  logic ts2, heat2, cof2, sug2, milk2, busy2, done2, fault2;
  logic [1:0] tv1, tv2;
  logic [2:0] stage1, stage2;

  int checks = 0;
  int failures = 0;
  int ts_count1 = 0;
  int done_count1 = 0;
  int q1[$];
  int q2[$];
  int tcnt1, tcnt2;

  brew_sequencer #(
    .WDOG_CYCLES (64)
  ) u1 (
    .clk_100MHz (clk), .reset (reset), .start (start),
    .size_large (size_large), .add_sugar (add_sugar),
    .add_milk (add_milk), .cancel (cancel), .t_expired (t_exp1),
    .timer_start (ts1), .timer_value (tv1), .heater_on (heat1),
    .coffee_valve (cof1), .sugar_valve (sug1), .milk_valve (milk1),
    .busy (busy1), .done (done1), .fault (fault1), .stage (stage1)
  );

  brew_sequencer #(
    .T_SUGAR     (2'd0),
    .WDOG_CYCLES (64)
  ) u2 (
    .clk_100MHz (clk), .reset (reset), .start (start2),
    .size_large (size_large), .add_sugar (add_sugar),
    .add_milk (add_milk), .cancel (cancel), .t_expired (t_exp2),
    .timer_start (ts2), .timer_value (tv2), .heater_on (heat2),
    .coffee_valve (cof2), .sugar_valve (sug2), .milk_valve (milk2),
    .busy (busy2), .done (done2), .fault (fault2), .stage (stage2)
  );

  // Timer models
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt1 <= 0;
      t_exp1 <= 1'b0;
    end else begin
      t_exp1 <= 1'b0;
      if (ts1) tcnt1 <= int'(tv1) * 4 - 1;
      else if (tcnt1 != 0) begin
        tcnt1 <= tcnt1 - 1;
        if (tcnt1 == 1 && !suppress) t_exp1 <= 1'b1;
      end
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt2 <= 0;
      t_exp2 <= 1'b0;
    end else begin
      t_exp2 <= 1'b0;
      if (ts2) tcnt2 <= int'(tv2) * 4 - 1;
      else if (tcnt2 != 0) begin
        tcnt2 <= tcnt2 - 1;
        if (tcnt2 == 1) t_exp2 <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic bad(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event seen, none expected", name);
  endtask

  // Monitors
  always @(negedge clk) begin
    if (!reset) begin
      if (busy1) chk("onehot0_u1", int'($onehot0({heat1, cof1, sug1, milk1})), 1);
      if (ts1) begin
        ts_count1++;
        chk("ts_onehot_u1", int'($onehot({heat1, cof1, sug1, milk1})), 1);
        if (q1.size() == 0) bad("unexpected_ts_u1");
        else chk("ts_value_u1", int'(tv1), q1.pop_front());
      end
      if (done1) begin
        done_count1++;
        if (q1.size() == 0) bad("unexpected_done_u1");
        else chk("done_u1", EV_DONE, q1.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (sug2) bad("sugar_valve_u2");
      if (ts2) begin
        if (q2.size() == 0) bad("unexpected_ts_u2");
        else chk("ts_value_u2", int'(tv2), q2.pop_front());
      end
      if (done2) begin
        if (q2.size() == 0) bad("unexpected_done_u2");
        else chk("done_u2", EV_DONE, q2.pop_front());
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_s1(input logic [2:0] s, input string tag);
    int n;
    n = 0;
    while (stage1 != s && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (stage1 != s) bad(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, base_done, n, n_wait;
    bit seen;
    reset = 1'b1;
    start = 0; start2 = 0; size_large = 0;
    add_sugar = 0; add_milk = 0; cancel = 0; suppress = 0;
    repeat (2) @(negedge clk);
    chk("rst_outputs", int'({ts1, tv1, heat1, cof1, sug1, milk1,
                              busy1, done1, fault1, stage1}), 0);
    chk("rst_stage_u2", int'(stage2), int'(ST_IDLE));
    reset = 1'b0;
    @(negedge clk);

    // 1: plain brew
    base = ts_count1;
    q1.push_back(3); q1.push_back(2); q1.push_back(EV_DONE);
    pulse_start();
    chk("t1_busy", int'(busy1), 1);
    chk("t1_heat_arm", int'(stage1), int'(ST_HEAT));
    wait_s1(ST_IDLE, "t1_idle_timeout");
    repeat (3) @(negedge clk);
    chk("t1_ts_pulses", ts_count1 - base, 2);
    chk("t1_sb_empty", q1.size(), 0);

    // 2: large, sugar, milk
    size_large = 1; add_sugar = 1; add_milk = 1;
    base = ts_count1;
    q1.push_back(3); q1.push_back(2); q1.push_back(2);
    q1.push_back(1); q1.push_back(2); q1.push_back(EV_DONE);
    pulse_start();
    size_large = 0; add_sugar = 0; add_milk = 0;
    wait_s1(ST_IDLE, "t2_idle_timeout");
    repeat (3) @(negedge clk);
    chk("t2_ts_pulses", ts_count1 - base, 5);
    chk("t2_sb_empty", q1.size(), 0);

    // 3: cancel in COFFEE WAIT
    base_done = done_count1;
    q1.push_back(3); q1.push_back(2);
    pulse_start();
    wait_s1(ST_COFFEE, "t3_coffee_timeout");
    repeat (5) @(negedge clk);
    chk("t3_coffee_on", int'(cof1), 1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("t3_coffee_off", int'(cof1), 0);
    chk("t3_drain", int'(stage1), int'(ST_DRAIN));
    chk("t3_busy_drain", int'(busy1), 1);
    wait_s1(ST_IDLE, "t3_idle_timeout");
    chk("t3_busy_idle", int'(busy1), 0);
    repeat (3) @(negedge clk);
    chk("t3_no_done", done_count1 - base_done, 0);
    chk("t3_sb_empty", q1.size(), 0);

    // 4: lost expiry in HEAT
    suppress = 1'b1;
    q1.push_back(3);
    pulse_start();
    n = 0; n_wait = 0;
    while (!fault1 && n < 300) begin
      @(negedge clk);
      if (stage1 == ST_HEAT && !ts1) n_wait++;
      n++;
    end
    if (!fault1) bad("t4_fault_timeout");
    chk("t4_wait_cycles", n_wait, 64);
    chk("t4_fault_state", int'(stage1), int'(ST_FAULT));
    chk("t4_heater_off", int'(heat1), 0);
    chk("t4_busy_off", int'(busy1), 0);
    @(negedge clk);
    chk("t4_idle", int'(stage1), int'(ST_IDLE));
    chk("t4_fault_sticky", int'(fault1), 1);
    suppress = 1'b0;
    repeat (3) @(negedge clk);
    q1.push_back(3); q1.push_back(2); q1.push_back(EV_DONE);
    pulse_start();
    chk("t4_fault_cleared", int'(fault1), 0);
    wait_s1(ST_IDLE, "t4_idle_timeout");
    repeat (3) @(negedge clk);
    chk("t4_sb_empty", q1.size(), 0);

    // 5: sugar skipped by T_SUGAR=0
    add_sugar = 1; add_milk = 1;
    q2.push_back(3); q2.push_back(2); q2.push_back(2); q2.push_back(EV_DONE);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    n = 0; seen = 0;
    while (!seen && n < 400) begin
      @(negedge clk);
      seen = (stage2 == ST_COFFEE) && !ts2 && t_exp2;
      n++;
    end
    if (!seen) bad("t5_coffee_exp_timeout");
    @(negedge clk);
    chk("t5_milk_arm", int'(stage2), int'(ST_MILK));
    chk("t5_milk_ts", int'(ts2), 1);
    n = 0;
    while (stage2 != ST_IDLE && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (stage2 != ST_IDLE) bad("t5_idle_timeout");
    add_sugar = 0; add_milk = 0;
    repeat (3) @(negedge clk);
    chk("t5_sb_empty", q2.size(), 0);

    // 6: held start, then async reset in MILK
    q1.push_back(3); q1.push_back(2); q1.push_back(EV_DONE);
    start = 1'b1;
    @(negedge clk);
    wait_s1(ST_IDLE, "t6_idle_timeout");
    repeat (20) @(negedge clk);
    chk("t6_no_retrigger", int'(stage1), int'(ST_IDLE));
    chk("t6_busy_low", int'(busy1), 0);
    chk("t6_sb_empty", q1.size(), 0);
    start = 1'b0;
    @(negedge clk);
    add_milk = 1;
    q1.push_back(3); q1.push_back(2); q1.push_back(2);
    pulse_start();
    add_milk = 0;
    wait_s1(ST_MILK, "t6_milk_timeout");
    @(negedge clk);
    chk("t6_milk_on", int'(milk1), 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_outputs", int'({ts1, tv1, heat1, cof1, sug1, milk1,
                                  busy1, done1, fault1, stage1}), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_sb_empty_after_reset", q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
